// File: rtl/ysyx_210544_ibus_axi_rd_pkg.sv
// Shared widths and AXI constants for the instruction-bus AXI read bridge.
package ysyx_210544_ibus_axi_rd_pkg;

    localparam int BUS_64 = 64;
    localparam int BUS_32 = 32;

    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    // Pick the 32-bit instruction lane out of a 64-bit read beat.
    function automatic logic [BUS_32-1:0] lane_select(input logic [BUS_64-1:0] data,
                                                      input logic            upper);
        return upper ? data[63:32] : data[31:0];
    endfunction

endpackage

// File: rtl/ysyx_210544_ibus_axi_rd.sv
// Instruction fetch bus to AXI read bridge: one single-beat read per request,
// with a registered one-cycle ack carrying the selected 32-bit lane.
module ysyx_210544_ibus_axi_rd
    import ysyx_210544_ibus_axi_rd_pkg::*;
#(
    parameter logic [3:0] AXI_ID  = 4'd0,
    parameter logic [7:0] AXI_LEN = 8'd0
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_bus_req,
    input  logic [BUS_64-1:0] i_bus_addr,
    output logic              o_bus_ack,
    output logic [BUS_32-1:0] o_bus_rdata,
    output logic              o_bus_err,

    output logic              o_axi_ar_valid,
    input  logic              i_axi_ar_ready,
    output logic [BUS_64-1:0] o_axi_ar_addr,
    output logic [3:0]        o_axi_ar_id,
    output logic [7:0]        o_axi_ar_len,
    output logic [2:0]        o_axi_ar_size,
    output logic [1:0]        o_axi_ar_burst,

    input  logic              i_axi_r_valid,
    output logic              o_axi_r_ready,
    input  logic [BUS_64-1:0] i_axi_r_data,
    input  logic [1:0]        i_axi_r_resp,
    input  logic              i_axi_r_last,
    input  logic [3:0]        i_axi_r_id
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADDR = 2'd1;
    localparam logic [1:0] DATA = 2'd2;
    localparam logic [1:0] ACK  = 2'd3;

    logic [1:0]        state;
    logic [BUS_64-1:0] addr_q;

    // Single-beat reads only, so the beat's last flag and id carry no information.
    logic unused_r_fields;
    assign unused_r_fields = ^{i_axi_r_last, i_axi_r_id};

    // The AR address comes straight from the latched request address register.
    assign o_axi_ar_addr  = addr_q;
    assign o_axi_ar_id    = AXI_ID;
    assign o_axi_ar_len   = AXI_LEN;
    assign o_axi_ar_size  = AXI_SIZE_4B;
    assign o_axi_ar_burst = AXI_BURST_INCR;

    // Fetch FSM: latch request, issue AR, wait for the beat, pulse ack, return to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            addr_q         <= '0;
            o_bus_ack      <= 1'b0;
            o_bus_rdata    <= '0;
            o_bus_err      <= 1'b0;
            o_axi_ar_valid <= 1'b0;
            o_axi_r_ready  <= 1'b0;
        end else begin
            o_bus_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_bus_req) begin
                        addr_q         <= i_bus_addr;
                        o_axi_ar_valid <= 1'b1;
                        o_bus_err      <= 1'b0;
                        state          <= ADDR;
                    end
                end
                ADDR: begin
                    if (i_axi_ar_ready) begin
                        o_axi_ar_valid <= 1'b0;
                        o_axi_r_ready  <= 1'b1;
                        state          <= DATA;
                    end
                end
                DATA: begin
                    if (i_axi_r_valid) begin
                        o_axi_r_ready <= 1'b0;
                        o_bus_ack     <= 1'b1;
                        if (i_axi_r_resp != AXI_RESP_OKAY) begin
                            o_bus_err   <= 1'b1;
                            o_bus_rdata <= '0;
                        end else begin
                            o_bus_rdata <= lane_select(i_axi_r_data, addr_q[2]);
                        end
                        state <= ACK;
                    end
                end
                ACK: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_210544_ibus_axi_rd.sv
// Directed bench for the instruction-bus AXI read bridge: a vector table of
// single fetches plus hand-written back-to-back and mid-transaction reset sequences.
module tb_ysyx_210544_ibus_axi_rd;

    logic        clk = 1'b0;
    logic        rst;
    logic        busReq;
    logic [63:0] busAddr;
    logic        busAck;
    logic [31:0] busRdata;
    logic        busErr;
    logic        arValid;
    logic        arReady;
    logic [63:0] arAddr;
    logic [3:0]  arId;
    logic [7:0]  arLen;
    logic [2:0]  arSize;
    logic [1:0]  arBurst;
    logic        rValid;
    logic        rReady;
    logic [63:0] rData;
    logic [1:0]  rResp;
    logic        rLast;
    logic [3:0]  rId;

    int checks = 0;
    int errors = 0;
    int cycleCount = 0;

    typedef struct {
        logic [63:0] addr;
        logic [63:0] data;
        logic [1:0]  resp;
        int          arDelay;
        int          rDelay;
        bit          dropReq;
        logic [31:0] expData;
        logic        expErr;
        int          expLat;
        string       name;
    } vec_t;

    vec_t vecs[8];

    ysyx_210544_ibus_axi_rd #(
        .AXI_ID (4'd5),
        .AXI_LEN(8'd0)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_bus_req     (busReq),
        .i_bus_addr    (busAddr),
        .o_bus_ack     (busAck),
        .o_bus_rdata   (busRdata),
        .o_bus_err     (busErr),
        .o_axi_ar_valid(arValid),
        .i_axi_ar_ready(arReady),
        .o_axi_ar_addr (arAddr),
        .o_axi_ar_id   (arId),
        .o_axi_ar_len  (arLen),
        .o_axi_ar_size (arSize),
        .o_axi_ar_burst(arBurst),
        .i_axi_r_valid (rValid),
        .o_axi_r_ready (rReady),
        .i_axi_r_data  (rData),
        .i_axi_r_resp  (rResp),
        .i_axi_r_last  (rLast),
        .i_axi_r_id    (rId)
    );

    always #5 clk = ~clk;

    // Free-running cycle counter used to timestamp AR issue.
    always @(posedge clk) cycleCount <= cycleCount + 1;

    // Runaway guard so the bench always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Drive one fetch and act as the AXI slave with the vector's stall counts.
    task automatic applyStimulus(input vec_t v, input bit holdReq, input logic [63:0] nextAddr,
                                 output int arCycle);
        int cyc;
        int arWait;
        int rWait;
        bit sawAr;
        bit arAccepted;
        bit arBad;
        bit overlap;
        bit done;
        cyc = 0; arWait = 0; rWait = 0;
        sawAr = 0; arAccepted = 0; arBad = 0; overlap = 0; done = 0;
        arCycle = -1;
        busReq = 1'b1; busAddr = v.addr;
        arReady = 1'b0; rValid = 1'b0; rData = v.data; rResp = v.resp;
        while (!done && cyc < 60) begin
            stepCycle();
            cyc++;
            if (arValid && rReady) overlap = 1;
            if (busAck) begin
                done = 1;
                arReady = 1'b0;
                rValid = 1'b0;
                checkOutput({v.name, " latency"}, cyc, v.expLat);
                checkOutput({v.name, " rdata"}, busRdata, v.expData);
                checkOutput({v.name, " err"}, busErr, v.expErr);
                if (holdReq) busAddr = nextAddr;
                else busReq = 1'b0;
            end else begin
                if (arValid) begin
                    if (!sawAr) begin
                        sawAr = 1;
                        arCycle = cycleCount;
                        checkOutput({v.name, " ar_addr"}, arAddr, v.addr);
                    end else if (arAddr !== v.addr) begin
                        arBad = 1;
                    end
                    arReady = (arWait >= v.arDelay);
                    if (arReady) arAccepted = 1;
                    arWait++;
                    if (v.dropReq) busReq = 1'b0;
                end else begin
                    if (sawAr && !arAccepted) arBad = 1;
                    arReady = 1'b0;
                end
                if (rReady) begin
                    rValid = (rWait >= v.rDelay);
                    rWait++;
                end else begin
                    rValid = 1'b0;
                end
            end
        end
        if (!done) checkOutput({v.name, " ack seen"}, 64'd0, 64'd1);
        checkOutput({v.name, " ar stable"}, arBad, 64'd0);
        checkOutput({v.name, " ar/r overlap"}, overlap, 64'd0);
        if (done && !holdReq) begin
            stepCycle();
            checkOutput({v.name, " ack one cycle"}, busAck, 64'd0);
            checkOutput({v.name, " rdata held"}, busRdata, v.expData);
            checkOutput({v.name, " err held"}, busErr, v.expErr);
        end
    endtask

    initial begin
        int arA;
        int arB;
        int ackCount;
        vec_t b2b0;
        vec_t b2b1;

        vecs[0] = '{64'h8000_0000, 64'h1111_2222_0000_0413, 2'b00, 0, 0, 1'b0, 32'h0000_0413, 1'b0, 3, "single lower"};
        vecs[1] = '{64'h8000_0004, 64'h1111_2222_0000_0413, 2'b00, 0, 0, 1'b0, 32'h1111_2222, 1'b0, 3, "single upper"};
        vecs[2] = '{64'h8000_0008, 64'hDEAD_BEEF_CAFE_F00D, 2'b10, 0, 0, 1'b0, 32'h0000_0000, 1'b1, 3, "slverr"};
        vecs[3] = '{64'h8000_000C, 64'hDEAD_BEEF_CAFE_F00D, 2'b00, 0, 0, 1'b0, 32'hDEAD_BEEF, 1'b0, 3, "okay after err"};
        vecs[4] = '{64'h8000_0010, 64'hAAAA_5555_1234_5678, 2'b00, 5, 3, 1'b0, 32'h1234_5678, 1'b0, 11, "stalls"};
        vecs[5] = '{64'h8000_0104, 64'h0BAD_F00D_7777_8888, 2'b11, 1, 0, 1'b0, 32'h0000_0000, 1'b1, 4, "decerr"};
        vecs[6] = '{64'h8000_0200, 64'h0BAD_F00D_7777_8888, 2'b01, 0, 2, 1'b0, 32'h0000_0000, 1'b1, 5, "exokay as err"};
        vecs[7] = '{64'h8000_0304, 64'h9999_AAAA_BBBB_CCCC, 2'b00, 2, 1, 1'b1, 32'h9999_AAAA, 1'b0, 6, "req drop"};

        rst = 1'b1; busReq = 1'b0; busAddr = '0;
        arReady = 1'b0; rValid = 1'b0; rData = '0; rResp = 2'b00; rLast = 1'b1; rId = 4'd0;
        repeat (2) stepCycle();

        checkOutput("reset ack", busAck, 64'd0);
        checkOutput("reset rdata", busRdata, 64'd0);
        checkOutput("reset err", busErr, 64'd0);
        checkOutput("reset ar_valid", arValid, 64'd0);
        checkOutput("reset ar_addr", arAddr, 64'd0);
        checkOutput("reset r_ready", rReady, 64'd0);
        checkOutput("ar_id", arId, 64'd5);
        checkOutput("ar_len", arLen, 64'd0);
        checkOutput("ar_size", arSize, 64'd2);
        checkOutput("ar_burst", arBurst, 64'd1);

        rst = 1'b0;
        stepCycle();

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i], 1'b0, 64'd0, arA);
        end

        // Back-to-back: request stays high and moves to the upper lane after ack.
        b2b0 = '{64'h8000_0000, 64'h1111_2222_0000_0413, 2'b00, 0, 0, 1'b0, 32'h0000_0413, 1'b0, 3, "b2b first"};
        b2b1 = '{64'h8000_0004, 64'h1111_2222_0000_0413, 2'b00, 0, 0, 1'b0, 32'h1111_2222, 1'b0, 4, "b2b second"};
        applyStimulus(b2b0, 1'b1, 64'h8000_0004, arA);
        applyStimulus(b2b1, 1'b0, 64'd0, arB);
        checkOutput("b2b ar spacing", arB - arA, 64'd4);

        // Reset while waiting for the read beat abandons the fetch silently.
        busReq = 1'b1; busAddr = 64'h8000_0004;
        rData = 64'h5555_6666_7777_8888; rResp = 2'b00;
        for (int i = 0; i < 20 && !rReady; i++) begin
            arReady = arValid;
            stepCycle();
        end
        arReady = 1'b0;
        checkOutput("rst reached DATA", rReady, 64'd1);
        rst = 1'b1; busReq = 1'b0;
        stepCycle();
        checkOutput("midrst ack", busAck, 64'd0);
        checkOutput("midrst rdata", busRdata, 64'd0);
        checkOutput("midrst err", busErr, 64'd0);
        checkOutput("midrst ar_valid", arValid, 64'd0);
        checkOutput("midrst ar_addr", arAddr, 64'd0);
        checkOutput("midrst r_ready", rReady, 64'd0);
        rst = 1'b0;
        ackCount = 0;
        for (int i = 0; i < 6; i++) begin
            stepCycle();
            if (busAck) ackCount++;
        end
        checkOutput("midrst no ack", ackCount, 64'd0);
        applyStimulus(vecs[1], 1'b0, 64'd0, arA);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_210544_ibus_axi_rd.md
YSYX_210544_IBUS_AXI_RD -- requirements
Module: ysyx_210544_ibus_axi_rd

Interface
REQ-001 The block SHALL take parameter AXI_ID, default 4'd0: value driven on o_axi_ar_id.
REQ-002 The block SHALL take parameter AXI_LEN, default 8'd0: value driven on o_axi_ar_len (single beat).
REQ-003 The block SHALL use one clock and a synchronous, active-high reset, with ports as below.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 i_bus_req  input  1  fetch request; held high by the requester until ack.
REQ-007 i_bus_addr  input  64  fetch byte address, 4-byte aligned.
REQ-008 o_bus_ack  output  1  one-cycle completion pulse.
REQ-009 o_bus_rdata  output  32  instruction word; valid while o_bus_ack is high.
REQ-010 o_bus_err  output  1  response error flag; valid while o_bus_ack is high.
REQ-011 o_axi_ar_valid / i_axi_ar_ready  output/input  1/1  AXI read-address handshake.
REQ-012 o_axi_ar_addr  output  64  read address.
REQ-013 o_axi_ar_id / o_axi_ar_len / o_axi_ar_size / o_axi_ar_burst  output  4/8/3/2  AR attributes.
REQ-014 i_axi_r_valid / o_axi_r_ready  input/output  1/1  AXI read-data handshake.
REQ-015 i_axi_r_data / i_axi_r_resp / i_axi_r_last / i_axi_r_id  input  64/2/1/4  read-data beat.

Function
REQ-016 FSM states SHALL be IDLE, ADDR, DATA and ACK, and all outputs SHALL be registered.
REQ-017 In IDLE, when i_bus_req=1, the block SHALL latch i_bus_addr into addr_q and go to ADDR; otherwise it SHALL stay in IDLE.
REQ-018 In ADDR, o_axi_ar_valid=1 and o_axi_ar_addr=addr_q SHALL hold stable until i_axi_ar_ready=1, then the FSM SHALL go to DATA.
REQ-019 AR attributes SHALL be constant: size=3'b010 (4 B), burst=2'b01 (INCR), len=AXI_LEN, id=AXI_ID.
REQ-020 In DATA, o_axi_r_ready=1; on i_axi_r_valid=1, the block SHALL capture the beat and go to ACK; i_axi_r_last and i_axi_r_id SHALL be ignored.
REQ-021 Lane select SHALL be: o_bus_rdata = addr_q[2] ? r_data[63:32] : r_data[31:0].
REQ-022 If i_axi_r_resp != 2'b00, the block SHALL set o_bus_err=1 and o_bus_rdata=32'h0.
REQ-023 In ACK, o_bus_ack=1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-024 o_bus_rdata SHALL hold its last value after ack until the next capture.
REQ-025 o_bus_err SHALL be cleared at the next IDLE->ADDR transition.
REQ-026 Minimum latency SHALL be 3 cycles from i_bus_req sampled in IDLE to o_bus_ack, with ar_ready and r_valid both ready immediately.
REQ-027 If i_bus_req drops after being sampled, the AXI transaction SHALL complete and ack SHALL still pulse (AXI cannot abort).
REQ-028 If i_bus_req is still high with a new address in the cycle after ack, it SHALL be accepted in IDLE with no extra bubble; back-to-back period is 4 cycles minimum.
REQ-029 At most one AXI transaction SHALL be outstanding; ar_valid and r_ready SHALL never be high in the same cycle.
REQ-030 Once asserted, o_axi_ar_valid SHALL NOT deassert before i_axi_ar_ready.

Reset
REQ-031 On rst=1 at a clock edge, the FSM SHALL go to IDLE and addr_q, o_bus_ack, o_bus_rdata, o_bus_err, o_axi_ar_valid, o_axi_ar_addr and o_axi_r_ready SHALL all clear to 0.
REQ-032 Reset in any state SHALL abandon the transaction with no ack, and the AXI slave SHALL be reset in the same cycle.

Structure
REQ-033 Width macros BUS_64/BUS_32 and AXI constants (AXI_SIZE_4B, AXI_BURST_INCR, AXI_RESP_OKAY) SHALL live in shared defines.v.
REQ-034 State encoding SHALL be a localparam inside the module.
REQ-035 The block SHALL be a single module with no sub-module (the FSM and lane mux are too small to split).

Verification
REQ-036 Single fetch: req with addr 0x8000_0000, ar_ready=1, r_data=0x1111_2222_0000_0413, resp=0 -> ar_addr=0x8000_0000; ack 3 cycles after req with rdata=0x0000_0413 and err=0.
REQ-037 Upper lane: addr 0x8000_0004, same data -> rdata=0x1111_2222.
REQ-038 Stalls: ar_ready held low for 5 cycles, then r_valid delayed 3 cycles -> ar_valid and addr stay stable throughout; exactly one ack with correct data.
REQ-039 Error: resp=2'b10 -> ack with err=1 and rdata=0; next fetch with OKAY response -> err=0.
REQ-040 Back-to-back: req held high, addr 0x8000_0000 then 0x8000_0004 after ack -> two AR transactions 4 cycles apart and two acks with the correct lanes.
REQ-041 Reset mid-DATA: rst asserted while r_ready=1 -> next cycle all outputs are 0 and no ack; a fresh fetch then completes normally.
